pattern_loader: RTL and testbench

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader_if.sv | 22 ++
 rtl/pattern_loader.sv | 153 +++++++++++++++
 tb/tb_pattern_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_loader_if.sv
// Row-write bus between the pattern loader and the board memory.
// Ports: mem_rdy (mem->loader), wr_en/wr_addr/wr_data (loader->mem).
interface pattern_loader_if;
    logic       mem_rdy;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        input  mem_rdy,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output mem_rdy,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/pattern_loader.sv
// Serial 8x8 pattern receiver; writes each assembled row to board memory.
// Ports: ph1, reset (async low), cs_n/sclk/sdata (async serial in),
//        mem (row-write bus), busy, done, frame_err (status).
module pattern_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdata,
    pattern_loader_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] WAIT_WR = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] sd_sr;
    logic                   cs_h;
    logic                   sclk_h;

    logic [1:0] state;
    logic [7:0] shreg;
    logic [7:0] rowbuf;
    logic [2:0] bitcnt;
    logic [2:0] rowcnt;
    logic       pend;
    logic [2:0] addr_q;
    logic [7:0] data_q;

    logic       cs_s;
    logic       sclk_s;
    logic       sd_s;
    logic       cs_fall;
    logic       cs_rise;
    logic       sclk_rise;
    logic       wr;
    logic [3:0] new_idx;

    // cs_n idles high so its chain resets to 1; no false frame start.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            cs_sr   <= '1;
            sclk_sr <= '0;
            sd_sr   <= '0;
            cs_h    <= 1'b1;
            sclk_h  <= 1'b0;
        end else begin
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            sd_sr   <= {sd_sr[SYNC_STAGES-2:0], sdata};
            cs_h    <= cs_sr[SYNC_STAGES-1];
            sclk_h  <= sclk_sr[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign sd_s      = sd_sr[SYNC_STAGES-1];
    assign cs_fall   = ~cs_s & cs_h;
    assign cs_rise   = cs_s & ~cs_h;
    assign sclk_rise = sclk_s & ~sclk_h;

    // A frame edge discards the pending row, so no write on that cycle.
    assign wr      = pend & mem.mem_rdy & ~cs_rise & ~cs_fall;
    // Index the completing row takes once the current write retires.
    assign new_idx = {1'b0, rowcnt} + {3'b000, wr};

    assign mem.wr_en   = wr;
    assign mem.wr_addr = wr ? rowcnt : addr_q;
    assign mem.wr_data = wr ? rowbuf : data_q;
    assign busy        = (state == SHIFT) | (state == WAIT_WR);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            rowbuf    <= '0;
            bitcnt    <= '0;
            rowcnt    <= '0;
            pend      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr) begin
                addr_q <= rowcnt;
                data_q <= rowbuf;
            end
            if (cs_fall) begin
                state     <= SHIFT;
                shreg     <= '0;
                bitcnt    <= '0;
                rowcnt    <= '0;
                pend      <= 1'b0;
                done      <= 1'b0;
                frame_err <= 1'b0;
            end else if (cs_rise && busy) begin
                state     <= IDLE;
                pend      <= 1'b0;
                frame_err <= 1'b1;
            end else if (cs_rise && state == DONE) begin
                state <= IDLE;
            end else begin
                if (wr) begin
                    pend   <= 1'b0;
                    rowcnt <= rowcnt + 3'd1;
                end
                unique case (state)
                    SHIFT: begin
                        if (sclk_rise) begin
                            shreg  <= {shreg[6:0], sd_s};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                if (!pend || wr) begin
                                    rowbuf <= {shreg[6:0], sd_s};
                                    pend   <= 1'b1;
                                    if (new_idx == 4'd7)
                                        state <= WAIT_WR;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                    end
                    WAIT_WR: begin
                        if (sclk_rise)
                            frame_err <= 1'b1;
                        if (wr && rowcnt == 3'd7) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (sclk_rise && !cs_s)
                            frame_err <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Randomized bench for pattern_loader with a frame-level write model.
// Ports: drives ph1/reset/serial pins and mem_rdy; watches row writes.
module tb_pattern_loader;

    logic ph1   = 1'b0;
    logic reset = 1'b0;
    logic cs_n  = 1'b1;
    logic sclk  = 1'b0;
    logic sdata = 1'b0;
    logic busy;
    logic done;
    logic frame_err;

    pattern_loader_if mif ();

    pattern_loader #(.SYNC_STAGES(2)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .sdata     (sdata),
        .mem       (mif.master),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 ph1 = ~ph1;

    int          checks   = 0;
    int          failures = 0;
    logic [10:0] wq[$];
    logic [7:0]  rows[8];
    bit          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory side: record every row write as {addr, data}.
    always @(negedge ph1)
        if (mif.wr_en === 1'b1)
            wq.push_back({mif.wr_addr, mif.wr_data});

    always @(posedge ph1)
        if (rand_rdy) begin
            #1;
            mif.mem_rdy = 1'($urandom_range(0, 1));
        end

    task automatic cyc(input int n);
        repeat (n) @(posedge ph1);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        cyc(6);
        sclk = 1'b1;
        cyc(6);
        sclk = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] r);
        for (int i = 7; i >= 0; i--)
            send_bit(r[i]);
    endtask

    task automatic start_frame();
        wq.delete();
        cs_n = 1'b0;
        cyc(10);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        cyc(10);
    endtask

    // Expected: rows[0..n-1] written once each, in address order.
    task automatic check_writes(input string tag, input int n);
        chk({tag, "_cnt"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++)
            chk({tag, "_row"}, {21'd0, wq[i]}, {21'd0, i[2:0], rows[i]});
    endtask

    task automatic random_rows();
        for (int i = 0; i < 8; i++)
            rows[i] = 8'($urandom);
    endtask

    initial begin
        mif.mem_rdy = 1'b0;
        cyc(3);
        chk("rst_wr_en", mif.wr_en, 0);
        chk("rst_addr", mif.wr_addr, 0);
        chk("rst_data", mif.wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", frame_err, 0);
        reset = 1'b1;
        cyc(5);

        // Walking pattern, memory always ready.
        rows = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        mif.mem_rdy = 1'b1;
        start_frame();
        chk("walk_busy", busy, 1);
        for (int i = 0; i < 8; i++)
            send_row(rows[i]);
        cyc(10);
        check_writes("walk", 8);
        chk("walk_done", done, 1);
        chk("walk_err", frame_err, 0);
        chk("walk_idle", busy, 0);
        chk("walk_hold_addr", mif.wr_addr, 7);
        chk("walk_hold_data", mif.wr_data, 8'h81);
        end_frame();
        chk("walk_done_kept", done, 1);

        // Random rows, memory ready toggling at random.
        for (int f = 0; f < 3; f++) begin
            random_rows();
            rand_rdy = 1'b1;
            start_frame();
            for (int i = 0; i < 8; i++)
                send_row(rows[i]);
            cyc(200);
            rand_rdy = 1'b0;
            cyc(2);
            check_writes("rand", 8);
            chk("rand_done", done, 1);
            chk("rand_err", frame_err, 0);
            end_frame();
        end

        // Late mem_rdy: write lands the cycle it rises.
        random_rows();
        mif.mem_rdy = 1'b0;
        start_frame();
        send_row(rows[0]);
        cyc(20);
        chk("late_nowr", wq.size(), 0);
        mif.mem_rdy = 1'b1;
        @(negedge ph1);
        chk("late_wr_en", mif.wr_en, 1);
        chk("late_addr", mif.wr_addr, 0);
        chk("late_data", mif.wr_data, rows[0]);
        cyc(1);
        for (int i = 1; i < 8; i++)
            send_row(rows[i]);
        cyc(10);
        check_writes("late", 8);
        chk("late_done", done, 1);
        chk("late_err", frame_err, 0);
        end_frame();

        // Overrun: row 1 lands while row 0 is still pending.
        random_rows();
        mif.mem_rdy = 1'b0;
        start_frame();
        send_row(rows[0]);
        send_row(rows[1]);
        cyc(10);
        chk("ovr_err", frame_err, 1);
        chk("ovr_nowr", wq.size(), 0);
        mif.mem_rdy = 1'b1;
        cyc(5);
        end_frame();
        check_writes("ovr", 1);
        chk("ovr_busy", busy, 0);
        chk("ovr_done", done, 0);

        // Abort after 20 bits.
        random_rows();
        mif.mem_rdy = 1'b1;
        start_frame();
        send_row(rows[0]);
        send_row(rows[1]);
        for (int i = 7; i >= 4; i--)
            send_bit(rows[2][i]);
        end_frame();
        cyc(20);
        check_writes("abort", 2);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", frame_err, 1);

        // Reset mid-frame with a row pending.
        random_rows();
        mif.mem_rdy = 1'b0;
        start_frame();
        send_row(rows[0]);
        send_row(rows[1]);
        send_row(rows[2]);
        for (int i = 7; i >= 2; i--)
            send_bit(rows[3][i]);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_wr_en", mif.wr_en, 0);
        chk("mrst_addr", mif.wr_addr, 0);
        chk("mrst_data", mif.wr_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", frame_err, 0);
        cs_n = 1'b1;
        mif.mem_rdy = 1'b1;
        cyc(3);
        reset = 1'b1;
        wq.delete();
        cyc(40);
        chk("mrst_nowr", wq.size(), 0);
        chk("mrst_idle", busy, 0);

        // Excess sclk edges after a complete frame.
        random_rows();
        mif.mem_rdy = 1'b1;
        start_frame();
        for (int i = 0; i < 8; i++)
            send_row(rows[i]);
        for (int i = 0; i < 4; i++)
            send_bit(1'($urandom));
        cyc(10);
        check_writes("xs", 8);
        chk("xs_done", done, 1);
        chk("xs_err", frame_err, 1);
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
